// File: rtl/xadc_drp_writer_if.sv
// Purpose : command write port plus the DRP write pins of xadc_drp_writer, bundled.
// Latency : none (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake; drdy_in ends each DRP write.
//
// master: the writer side (takes commands, drives the DRP pins).
// slave : the requester / XADC side (drives commands and drdy_in).
interface xadc_drp_writer_if;
  logic        cmd_valid;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic [6:0]  daddr_out;
  logic [15:0] di_out;
  logic        den_out;
  logic        dwe_out;
  logic        drdy_in;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data, drdy_in,
    output cmd_ready, daddr_out, di_out, den_out, dwe_out
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data, drdy_in,
    input  cmd_ready, daddr_out, di_out, den_out, dwe_out
  );
endinterface

// File: rtl/xadc_drp_writer.sv
// Purpose : DRP write master; keeps XADC reg 0x49 in step with sw, plus command writes.
// Latency : accept -> den_out next cycle; drdy_in -> done next cycle; err TIMEOUT+1 after den.
// Backpressure: cmd_ready only when idle, started and no auto rewrite pending.
//
// Ports: clk/rst_n (async, active low); sw asynchronous switches; bus = command
// port + DRP write pins (master modport); done/err one-cycle result pulses,
// src tags the result (1 = auto write of 0x49, 0 = command write).
module xadc_drp_writer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       sw,
  xadc_drp_writer_if.master bus,
  output logic             done,
  output logic             err,
  output logic             src
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT - 1);
  localparam logic [6:0] AUTO_ADDR = 7'h49;

  logic [3:0]  sw_meta_q, sw_s_q, sw_last_q;
  logic [1:0]  start_cnt_q, start_cnt_d;
  logic        pend_q, pend_d;
  state_t      state_q, state_d;
  logic [9:0]  tmo_cnt_q, tmo_cnt_d;
  logic [6:0]  daddr_q, daddr_d;
  logic [15:0] di_q, di_d;
  logic        den_q, den_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        src_q, src_d;

  logic        startup_done;
  logic        sw_changed;
  logic [15:0] auto_word;

  assign startup_done = (start_cnt_q == 2'd3);
  assign sw_changed   = (sw_s_q != sw_last_q);

  // Channel-select bits: vaux15, vaux14 in the high byte, vaux7, vaux6 in the low byte.
  assign auto_word = {sw_s_q[2], sw_s_q[0], 6'b0, sw_s_q[1], sw_s_q[3], 6'b0};

  always_comb begin
    start_cnt_d = startup_done ? start_cnt_q : start_cnt_q + 2'd1;
    pend_d      = pend_q;
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    daddr_d     = daddr_q;
    di_d        = di_q;
    src_d       = src_q;
    den_d       = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (startup_done) begin
          if (pend_q) begin
            daddr_d = AUTO_ADDR;
            di_d    = auto_word;
            src_d   = 1'b1;
            pend_d  = 1'b0;
            den_d   = 1'b1;
            state_d = S_ISSUE;
          end else if (bus.cmd_valid) begin
            daddr_d = bus.cmd_addr;
            di_d    = bus.cmd_data;
            src_d   = 1'b0;
            den_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (bus.drdy_in) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          // A lost auto write must be retried so 0x49 still tracks the switches.
          if (src_q) pend_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Last so that a change coinciding with a clear still leaves a rewrite queued.
    if (sw_changed) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q   <= '0;
      sw_s_q      <= '0;
      sw_last_q   <= '0;
      start_cnt_q <= '0;
      pend_q      <= 1'b1;
      state_q     <= S_IDLE;
      tmo_cnt_q   <= '0;
      daddr_q     <= '0;
      di_q        <= '0;
      den_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      src_q       <= 1'b0;
    end else begin
      // Two-flop synchronizer for the asynchronous switches.
      sw_meta_q   <= sw;
      sw_s_q      <= sw_meta_q;
      sw_last_q   <= sw_s_q;
      start_cnt_q <= start_cnt_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      daddr_q     <= daddr_d;
      di_q        <= di_d;
      den_q       <= den_d;
      done_q      <= done_d;
      err_q       <= err_d;
      src_q       <= src_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE) & startup_done & ~pend_q;
  assign bus.daddr_out = daddr_q;
  assign bus.di_out    = di_q;
  assign bus.den_out   = den_q;
  // Every transfer from this block is a write, so dwe shares the den flop.
  assign bus.dwe_out   = den_q;
  assign done          = done_q;
  assign err           = err_q;
  assign src           = src_q;

endmodule
